// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial-in / byte-out signal bundle for uart_rx
interface uart_rx_if;
  logic        clk_en;
  logic        ser_rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic [31:0] rx_sum;
  logic        busy;

  modport master (
    output clk_en, ser_rx,
    input  rx_data, rx_valid, rx_error, rx_sum, busy
  );

  modport slave (
    input  clk_en, ser_rx,
    output rx_data, rx_valid, rx_error, rx_sum, busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with framing-error flag and running byte sum
module uart_rx #(
  parameter int unsigned clocks_per_bit = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam logic [15:0] HALF_M1 = 16'(clocks_per_bit / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(clocks_per_bit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic        sync_q, line_q;
  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic [31:0] sum_q, sum_d;
  logic        tick, count_zero;

  assign tick       = bus.clk_en;
  assign count_zero = (count_q == 16'd0);

  // Synchronizer runs every clk so line latency does not depend on tick spacing.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync_q <= bus.ser_rx;
      line_q <= sync_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    sum_d     = sum_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (armed_q && !line_q) begin
            state_d = START;
            count_d = HALF_M1;
          end else if (line_q) begin
            armed_d = 1'b1;
          end
        end
        START: begin
          if (!count_zero) begin
            count_d = count_q - 16'd1;
          end else if (!line_q) begin
            state_d   = DATA;
            count_d   = FULL_M1;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
            armed_d = 1'b1;
          end
        end
        DATA: begin
          if (count_zero) begin
            shift_d = {line_q, shift_q[7:1]};
            count_d = FULL_M1;
            if (bit_idx_q == 3'd7) state_d = STOP;
            else bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            count_d = count_q - 16'd1;
          end
        end
        STOP: begin
          if (!count_zero) begin
            count_d = count_q - 16'd1;
          end else if (line_q) begin
            data_d  = shift_q;
            sum_d   = sum_q + {24'd0, shift_q};
            valid_d = 1'b1;
            state_d = IDLE;
            armed_d = 1'b1;
          end else begin
            // A held-low line after a bad stop must go high before re-arming.
            error_d = 1'b1;
            state_d = IDLE;
            armed_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      count_q   <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      sum_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      sum_q     <= sum_d;
    end
  end

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.rx_error = error_q;
  assign bus.rx_sum   = sum_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven and randomized frame checks for uart_rx
module tb_uart_rx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if bus();

  uart_rx #(.clocks_per_bit(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    logic [31:0] sum;
    int          tick;
  } ev_t;

  typedef struct {
    logic [7:0]  data;
    bit          stop_ok;
    int          period;
    int          extra_low;
    int          gap;
    logic [7:0]  exp_data;
    logic [31:0] exp_sum;
    bit          exp_err;
  } vec_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  ev_t         got_e;
  vec_t        vecs[5];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          tick_cnt = 0;
  int          period = 1;
  logic [7:0]  mdl_data = 8'd0;
  logic [31:0] mdl_sum = 32'd0;
  logic        prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // One call = one tick, preceded by period-1 clocks with clk_en low.
  task automatic do_tick();
    for (int i = 0; i < period - 1; i++) begin
      bus.clk_en = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.clk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.clk_en = 1'b0;
    tick_cnt++;
  endtask

  task automatic drive(input logic v, input int n);
    bus.ser_rx = v;
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // Reference model: a good frame updates data/sum; the pulse lands on the stop-sample
  // tick, counted from the first tick that can see the start edge through 2 sync flops.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int extra_low,
                            input int gap);
    ev_t e;
    e.tick = tick_cnt + (period + 2) / period + CPB / 2 + 9 * CPB;
    if (stop_ok) begin
      mdl_data = d;
      mdl_sum  = mdl_sum + {24'd0, d};
    end
    e.is_err = !stop_ok;
    e.data   = mdl_data;
    e.sum    = mdl_sum;
    exp_q.push_back(e);
    drive(1'b0, CPB);
    for (int k = 0; k < 8; k++) drive(d[k], CPB);
    drive(stop_ok, CPB + extra_low);
    drive(1'b1, gap);
  endtask

  task automatic drain();
    int n = 0;
    bus.ser_rx = 1'b1;
    while (exp_q.size() != 0 && n < 500) begin
      do_tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      fail("drain_timeout");
      exp_q.delete();
    end
    drive(1'b1, 5);
  endtask

  always @(negedge clk) begin
    if (bus.rx_valid || bus.rx_error) begin
      check("pulse_exclusive", {31'd0, bus.rx_valid & bus.rx_error}, 32'd0);
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      check("busy_at_pulse", {31'd0, bus.busy}, 32'd0);
      got_e.is_err = bus.rx_error;
      got_e.data   = bus.rx_data;
      got_e.sum    = bus.rx_sum;
      got_e.tick   = tick_cnt;
      obs_q.push_back(got_e);
      if (exp_q.size() == 0) begin
        fail("unexpected_pulse");
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_kind_err", {31'd0, bus.rx_error}, {31'd0, e.is_err});
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
        check("rx_sum", bus.rx_sum, e.sum);
        check("pulse_tick", tick_cnt, e.tick);
      end
    end
    prev_pulse <= bus.rx_valid | bus.rx_error;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int p;
    bit ok;
    bus.ser_rx = 1'b1;
    bus.clk_en = 1'b0;

    vecs[0] = '{8'h55, 1'b1, 1, 0,  0, 8'h55, 32'h0000_0055, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1, 0,  2, 8'hA5, 32'h0000_00FA, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 4, 0,  2, 8'h3C, 32'h0000_0136, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1, 40, 3, 8'h3C, 32'h0000_0136, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1, 0,  3, 8'h01, 32'h0000_0137, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    period = 1;
    drive(1'b1, 100);
    check("idle_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("idle_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("idle_rx_error", {31'd0, bus.rx_error}, 32'd0);
    check("idle_rx_sum", bus.rx_sum, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    base = obs_q.size();
    for (int i = 0; i < 5; i++) begin
      period = vecs[i].period;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].extra_low, vecs[i].gap);
    end
    drain();
    check("tbl_count", obs_q.size() - base, 32'd5);
    for (int i = 0; i < 5 && base + i < obs_q.size(); i++) begin
      check("tbl_err", {31'd0, obs_q[base + i].is_err}, {31'd0, vecs[i].exp_err});
      check("tbl_data", {24'd0, obs_q[base + i].data}, {24'd0, vecs[i].exp_data});
      check("tbl_sum", obs_q[base + i].sum, vecs[i].exp_sum);
    end

    period = 1;
    base = obs_q.size();
    drive(1'b0, 1);
    drive(1'b1, 20);
    check("glitch_busy", {31'd0, bus.busy}, 32'd0);
    check("glitch_no_pulse", obs_q.size() - base, 32'd0);

    for (int f = 0; f < 60; f++) begin
      p  = $urandom_range(1, 4);
      ok = ($urandom_range(0, 7) != 0);
      if (p != period) drive(1'b1, 3);
      period = p;
      send_frame(8'($urandom_range(0, 255)), ok,
                 ok ? 0 : $urandom_range(0, 5),
                 ok ? $urandom_range(0, 3) : $urandom_range(2, 4));
    end
    drain();

    period = 1;
    base = obs_q.size();
    drive(1'b0, CPB);
    for (int k = 0; k < 4; k++) drive(1'b1, CPB);
    drive(1'b1, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_rx_error", {31'd0, bus.rx_error}, 32'd0);
    check("rst_rx_sum", bus.rx_sum, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    mdl_data = 8'd0;
    mdl_sum  = 32'd0;
    drive(1'b1, 2 + 3 * CPB);
    drive(1'b1, CPB);
    send_frame(8'h12, 1'b1, 0, 2);
    drain();
    check("post_rst_count", obs_q.size() - base, 32'd1);
    check("post_rst_data", {24'd0, bus.rx_data}, 32'h12);
    check("post_rst_sum", bus.rx_sum, 32'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
